// File: rtl/lane_pkg.sv
// ============================================================================
// Module: lane_pkg. Shared types, default constants and lane geometry helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lane_pkg;

  localparam int NUM_LANES_DEF    = 3;
  localparam int SQ_DEF           = 25;
  localparam int SPEED_DEF        = 1;
  localparam int X_MAX_DEF        = 640;
  localparam int LANE_Y0_DEF      = 100;
  localparam int LANE_PITCH_DEF   = 200;
  localparam int SPAWN_FRAMES_DEF = 60;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  typedef struct packed {
    logic        active;
    logic [15:0] x;
  } lane_t;

  // Top row of lane i, 17 bits so that adding SQ never wraps.
  function automatic logic [16:0] lane_y(input int i, input int y0, input int pitch);
    return 17'(y0 + i * pitch);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vs_tick.sv
// ============================================================================
// Module: vs_tick. Two-flop VGA_VS synchroniser plus registered falling-edge pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vs_tick (
  input  logic clk,
  input  logic rst,
  input  logic vs_n,
  output logic tick
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       tick_q, tick_d;

  always_comb begin
    sync_d = {sync_q[0], vs_n};
    prev_d = sync_q[1];
    tick_d = prev_q & ~sync_q[1];
  end

  // Idle-high reset so releasing rst with VS high never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/lane_scheduler.sv
// ============================================================================
// Module: lane_scheduler. Frame-driven spawn/advance of lane objects through one
// shared adder, plus registered lowest-lane-wins pixel arbitration.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lane_scheduler
  import lane_pkg::*;
#(
  parameter int NUM_LANES    = NUM_LANES_DEF,
  parameter int SQ           = SQ_DEF,
  parameter int SPEED        = SPEED_DEF,
  parameter int X_MAX        = X_MAX_DEF,
  parameter int LANE_Y0      = LANE_Y0_DEF,
  parameter int LANE_PITCH   = LANE_PITCH_DEF,
  parameter int SPAWN_FRAMES = SPAWN_FRAMES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 VGA_VS,
  input  logic [NUM_LANES-1:0] lane_en,
  input  logic [15:0]          xcount,
  input  logic [15:0]          ycount,
  output logic                 pix_hit,
  output logic [1:0]           pix_lane,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [1:0]  LAST_IDX   = 2'(NUM_LANES - 1);
  localparam logic [15:0] SPAWN_LAST = 16'(SPAWN_FRAMES - 1);

  logic tick;

  vs_tick u_vs_tick (
    .clk  (clk),
    .rst  (rst),
    .vs_n (VGA_VS),
    .tick (tick)
  );

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] spawn_cnt_q, spawn_cnt_d;
  logic        spawn_due_q, spawn_due_d;
  logic        overrun_q, overrun_d;
  logic        pix_hit_q, pix_hit_d;
  logic [1:0]  pix_lane_q, pix_lane_d;
  lane_t       lanes_q [NUM_LANES];
  lane_t       lanes_d [NUM_LANES];

  lane_t       cur, cur_next;
  logic [16:0] x_sum;
  logic        en_cur;

  // Single shared adder: only the lane selected by idx is advanced.
  always_comb begin
    cur      = lanes_q[idx_q];
    en_cur   = lane_en[idx_q];
    x_sum    = {1'b0, cur.x} + 17'(SPEED);
    cur_next = cur;
    if (cur.active) begin
      if (x_sum >= 17'(X_MAX)) begin
        cur_next.active = 1'b0;
        cur_next.x      = 16'd0;
      end else begin
        cur_next.x      = x_sum[15:0];
      end
    end else if (spawn_due_q && en_cur) begin
      cur_next.active = 1'b1;
      cur_next.x      = 16'd0;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    spawn_cnt_d = spawn_cnt_q;
    spawn_due_d = spawn_due_q;
    overrun_d   = overrun_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      lanes_d[i] = lanes_q[i];
    end
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d     = ST_SCAN;
          idx_d       = 2'd0;
          spawn_cnt_d = (spawn_cnt_q == SPAWN_LAST) ? 16'd0 : spawn_cnt_q + 16'd1;
          if (spawn_cnt_q == 16'd0) spawn_due_d = 1'b1;
        end
      end
      ST_SCAN: begin
        if (tick) overrun_d = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
          if (2'(i) == idx_q) lanes_d[i] = cur_next;
        end
        if (idx_q == LAST_IDX) begin
          state_d     = ST_IDLE;
          idx_d       = 2'd0;
          spawn_due_d = 1'b0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ascending scan with a found flag gives the lowest hitting lane priority.
  always_comb begin
    pix_hit_d  = 1'b0;
    pix_lane_d = 2'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!pix_hit_d && lanes_q[i].active &&
          ({1'b0, xcount} >= {1'b0, lanes_q[i].x}) &&
          ({1'b0, xcount} <  {1'b0, lanes_q[i].x} + 17'(SQ)) &&
          ({1'b0, ycount} >= lane_y(i, LANE_Y0, LANE_PITCH)) &&
          ({1'b0, ycount} <  lane_y(i, LANE_Y0, LANE_PITCH) + 17'(SQ))) begin
        pix_hit_d  = 1'b1;
        pix_lane_d = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      spawn_cnt_q <= 16'd0;
      spawn_due_q <= 1'b0;
      overrun_q   <= 1'b0;
      pix_hit_q   <= 1'b0;
      pix_lane_q  <= 2'd0;
      for (int i = 0; i < NUM_LANES; i++) begin
        lanes_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      spawn_cnt_q <= spawn_cnt_d;
      spawn_due_q <= spawn_due_d;
      overrun_q   <= overrun_d;
      pix_hit_q   <= pix_hit_d;
      pix_lane_q  <= pix_lane_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        lanes_q[i] <= lanes_d[i];
      end
    end
  end

  assign pix_hit  = pix_hit_q;
  assign pix_lane = pix_lane_q;
  assign busy     = (state_q == ST_SCAN);
  assign overrun  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_lane_scheduler.sv
// ============================================================================
// Module: tb_lane_scheduler. Random-frame bench for lane_scheduler against a
// frame-level model of spawn/advance/despawn and pixel ownership.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lane_scheduler;

  localparam int NL    = 3;
  localparam int SQ    = 25;
  localparam int XMAX  = 640;
  localparam int Y0    = 100;
  localparam int PITCH = 200;
  localparam int SPAWN = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        VGA_VS;
  logic [2:0]  lane_en;
  logic [2:0]  lane_en2;
  logic [15:0] xcount;
  logic [15:0] ycount;
  logic        pix_hit, pix_hit2;
  logic [1:0]  pix_lane, pix_lane2;
  logic        busy, busy2;
  logic        overrun, overrun2;

  lane_scheduler dut (
    .clk(clk), .rst(rst), .VGA_VS(VGA_VS), .lane_en(lane_en),
    .xcount(xcount), .ycount(ycount),
    .pix_hit(pix_hit), .pix_lane(pix_lane), .busy(busy), .overrun(overrun)
  );

  // Second instance with overlapping lanes to exercise the priority rule.
  lane_scheduler #(.LANE_PITCH(10)) dut2 (
    .clk(clk), .rst(rst), .VGA_VS(VGA_VS), .lane_en(lane_en2),
    .xcount(xcount), .ycount(ycount),
    .pix_hit(pix_hit2), .pix_lane(pix_lane2), .busy(busy2), .overrun(overrun2)
  );

  always #5 clk = ~clk;

  int total    = 0;
  int pass_cnt = 0;

  // Frame-level model: accepted tick count plus per-lane activity/position.
  int m_n;
  int m_act [NL];
  int m_x   [NL];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_n = 0;
    for (int i = 0; i < NL; i++) begin
      m_act[i] = 0;
      m_x[i]   = 0;
    end
  endtask

  task automatic model_tick(input logic [2:0] en);
    bit due;
    due = (m_n % SPAWN) == 0;
    m_n++;
    for (int i = 0; i < NL; i++) begin
      if (m_act[i] != 0) begin
        if (m_x[i] + 1 >= XMAX) begin
          m_act[i] = 0;
          m_x[i]   = 0;
        end else begin
          m_x[i] = m_x[i] + 1;
        end
      end else if (due && en[i]) begin
        m_act[i] = 1;
        m_x[i]   = 0;
      end
    end
  endtask

  // One frame: VS low 8 cycles (tick + full scan), high 4; counts busy cycles.
  task automatic do_frame(output int bc);
    bc = 0;
    VGA_VS = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (busy === 1'b1) bc++;
    end
    VGA_VS = 1'b1;
    repeat (4) @(negedge clk);
    model_tick(lane_en);
  endtask

  task automatic probe(input int x, input int y);
    int eh, el;
    xcount = 16'(x);
    ycount = 16'(y);
    @(negedge clk);
    eh = 0;
    el = 0;
    for (int i = 0; i < NL; i++) begin
      if (eh == 0 && m_act[i] != 0 && x >= m_x[i] && x < m_x[i] + SQ &&
          y >= Y0 + i * PITCH && y < Y0 + i * PITCH + SQ) begin
        eh = 1;
        el = i;
      end
    end
    chk($sformatf("pix_hit(%0d,%0d)", x, y), {31'd0, pix_hit}, eh);
    chk($sformatf("pix_lane(%0d,%0d)", x, y), {30'd0, pix_lane}, el);
  endtask

  task automatic probe_lanes();
    for (int i = 0; i < NL; i++) begin
      probe(m_x[i], Y0 + i * PITCH);
      probe(m_x[i] + SQ, Y0 + i * PITCH + SQ - 1);
      if (m_x[i] > 0) probe(m_x[i] - 1, Y0 + i * PITCH);
    end
  endtask

  task automatic probe_random();
    int l, px, py;
    l  = int'($urandom_range(NL - 1, 0));
    px = m_x[l] - 5 + int'($urandom_range(35, 0));
    if (px < 0) px = 0;
    py = Y0 + l * PITCH - 3 + int'($urandom_range(30, 0));
    probe(px, py);
    probe(int'($urandom_range(700, 0)), int'($urandom_range(700, 0)));
  endtask

  initial begin
    int bc;
    rst      = 1'b1;
    VGA_VS   = 1'b1;
    lane_en  = 3'b000;
    lane_en2 = 3'b111;
    xcount   = 16'd0;
    ycount   = 16'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pix_hit", {31'd0, pix_hit}, 0);
    chk("rst_pix_lane", {30'd0, pix_lane}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    rst = 1'b0;
    @(negedge clk);

    // First tick spawns enabled lanes 0 and 2.
    lane_en = 3'b101;
    do_frame(bc);
    chk("busy_cycles", bc, NL);
    probe_lanes();
    probe(0, Y0 + PITCH);

    // Overlapping instance: lanes 0/1/2 cover y 100..124, 110..134, 120..144.
    xcount = 16'd5;
    ycount = 16'd115;
    @(negedge clk);
    chk("ovl_hit_115", {31'd0, pix_hit2}, 1);
    chk("ovl_lane_115", {30'd0, pix_lane2}, 0);
    ycount = 16'd130;
    @(negedge clk);
    chk("ovl_lane_130", {30'd0, pix_lane2}, 1);
    ycount = 16'd140;
    @(negedge clk);
    chk("ovl_lane_140", {30'd0, pix_lane2}, 2);

    for (int f = 0; f < 10; f++) begin
      lane_en = 3'($urandom_range(7, 0));
      do_frame(bc);
    end
    probe(10, 100);
    probe(35, 100);
    probe(10, 125);

    // Long random run crosses the despawn at x=639 and later respawn windows.
    while (m_n < 700) begin
      lane_en = 3'($urandom_range(7, 0));
      do_frame(bc);
      if (m_n % 7 == 0 || (m_n >= 638 && m_n <= 665) || m_n % SPAWN <= 1) probe_lanes();
      probe_random();
    end

    // Two falling edges 2 cycles apart: second lands mid-scan.
    lane_en = 3'b111;
    VGA_VS = 1'b0;
    @(negedge clk);
    VGA_VS = 1'b1;
    @(negedge clk);
    VGA_VS = 1'b0;
    repeat (8) @(negedge clk);
    VGA_VS = 1'b1;
    repeat (4) @(negedge clk);
    model_tick(lane_en);
    chk("overrun_set", {31'd0, overrun}, 1);
    probe_lanes();
    do_frame(bc);
    chk("overrun_sticky", {31'd0, overrun}, 1);
    chk("busy_cycles2", bc, NL);
    probe_lanes();
    rst = 1'b1;
    @(negedge clk);
    chk("overrun_clr", {31'd0, overrun}, 0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    // Build some state, then reset during the second scan cycle.
    lane_en = 3'b111;
    for (int f = 0; f < 5; f++) do_frame(bc);
    probe_lanes();
    VGA_VS = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_mid", {31'd0, busy}, 1);
    rst    = 1'b1;
    VGA_VS = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_hit", {31'd0, pix_hit}, 0);
    chk("midrst_lane", {30'd0, pix_lane}, 0);
    chk("midrst_overrun", {31'd0, overrun}, 0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    probe(4, 100);
    probe(0, 100);
    probe(0, 300);
    lane_en = 3'b010;
    do_frame(bc);
    probe_lanes();
    probe(0, 100);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
